// File: rtl/stack_ctrl.sv
// Stack controller: PUSH/POP/CALL/RET sequencing against a byte RAM.
// Optional overflow/underflow guard enabled by defining STACK_GUARD_EN.
module stack_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_push,
    input  logic        req_pop,
    input  logic        req_call,
    input  logic        req_ret,
    input  logic [7:0]  push_data,
    input  logic [15:0] call_pc,
    input  logic        sp_wr,
    input  logic [7:0]  sp_wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sp,
    output logic [7:0]  pop_data,
    output logic [15:0] ret_pc,
    output logic        ovf,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        ram_is_bit_addr,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_in_data,
    input  logic [7:0]  ram_out_data
);

    typedef enum logic [2:0] {
        IDLE, WR1, WR2, RD1, RD2, CAP, DONE
    } state_t;

    state_t      state;
    logic        two;
    logic [15:0] lat;
    logic        any_req;
    logic        is_wr;
    logic        hit;
    logic        guard_call;
    logic        guard_ret;
    logic        guard_push;
    logic        guard_pop;

`ifdef STACK_GUARD_EN
    assign guard_call = (sp >= 8'h7E);
    assign guard_push = (sp >= 8'h7F);
    assign guard_ret  = (sp <  8'h09);
    assign guard_pop  = (sp <  8'h08);
`else
    assign guard_call = 1'b0;
    assign guard_push = 1'b0;
    assign guard_ret  = 1'b0;
    assign guard_pop  = 1'b0;
`endif

    assign any_req = req_call | req_ret | req_push | req_pop;
    assign is_wr   = req_call | (~req_ret & req_push);
    assign hit     = req_call ? guard_call :
                     req_ret  ? guard_ret  :
                     req_push ? guard_push : guard_pop;

    assign ram_is_bit_addr = 1'b0;

    // Sequencer: state, stack pointer, results and registered RAM strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sp          <= 8'h07;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            pop_data    <= 8'h00;
            ret_pc      <= 16'h0000;
            two         <= 1'b0;
            lat         <= 16'h0000;
            ram_rd      <= 1'b1;
            ram_wr      <= 1'b0;
            ram_addr    <= 8'h07;
            ram_in_data <= 8'h00;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    ram_rd      <= 1'b1;
                    ram_wr      <= 1'b0;
                    ram_in_data <= 8'h00;
                    ram_addr    <= sp;
                    if (any_req) begin
                        busy <= 1'b1;
                        two  <= req_call | req_ret;
                        lat  <= req_call ? call_pc : {8'h00, push_data};
                        if (hit) begin
                            ovf   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (is_wr) begin
                            state       <= WR1;
                            ram_rd      <= 1'b0;
                            ram_wr      <= 1'b1;
                            ram_addr    <= sp + 8'd1;
                            ram_in_data <= req_call ? call_pc[7:0] : push_data;
                        end else begin
                            state <= RD1;
                        end
                    end else if (sp_wr) begin
                        sp       <= sp_wdata;
                        ram_addr <= sp_wdata;
                        ovf      <= 1'b0;
                    end
                end
                WR1: begin
                    if (two) begin
                        state       <= WR2;
                        ram_addr    <= sp + 8'd2;
                        ram_in_data <= lat[15:8];
                    end else begin
                        state       <= DONE;
                        done        <= 1'b1;
                        sp          <= sp + 8'd1;
                        ram_rd      <= 1'b1;
                        ram_wr      <= 1'b0;
                        ram_addr    <= sp + 8'd1;
                        ram_in_data <= 8'h00;
                    end
                end
                WR2: begin
                    state       <= DONE;
                    done        <= 1'b1;
                    sp          <= sp + 8'd2;
                    ram_rd      <= 1'b1;
                    ram_wr      <= 1'b0;
                    ram_addr    <= sp + 8'd2;
                    ram_in_data <= 8'h00;
                end
                RD1: begin
                    if (two) begin
                        state    <= RD2;
                        ram_addr <= sp - 8'd1;
                    end else begin
                        state    <= CAP;
                        ram_addr <= sp;
                    end
                end
                RD2: begin
                    state        <= CAP;
                    ret_pc[15:8] <= ram_out_data;
                    ram_addr     <= sp;
                end
                CAP: begin
                    state <= DONE;
                    done  <= 1'b1;
                    if (two) begin
                        ret_pc[7:0] <= ram_out_data;
                        sp          <= sp - 8'd2;
                        ram_addr    <= sp - 8'd2;
                    end else begin
                        pop_data <= ram_out_data;
                        sp       <= sp - 8'd1;
                        ram_addr <= sp - 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ram_addr <= sp;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a RAM model and a write scoreboard.
// Covers both the default build and STACK_GUARD_EN builds.
module tb_stack_ctrl;

    logic        clk;
    logic        rst;
    logic        req_push, req_pop, req_call, req_ret;
    logic [7:0]  push_data;
    logic [15:0] call_pc;
    logic        sp_wr;
    logic [7:0]  sp_wdata;
    logic        busy, done, ovf;
    logic [7:0]  sp, pop_data;
    logic [15:0] ret_pc;
    logic        ram_rd, ram_wr, ram_is_bit_addr;
    logic [7:0]  ram_addr, ram_in_data, ram_out_data;

    int n_assert = 0;
    int n_fail   = 0;
    bit started  = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  mem [256];

    stack_ctrl dut (
        .clk(clk), .rst(rst),
        .req_push(req_push), .req_pop(req_pop),
        .req_call(req_call), .req_ret(req_ret),
        .push_data(push_data), .call_pc(call_pc),
        .sp_wr(sp_wr), .sp_wdata(sp_wdata),
        .busy(busy), .done(done), .sp(sp),
        .pop_data(pop_data), .ret_pc(ret_pc), .ovf(ovf),
        .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_is_bit_addr(ram_is_bit_addr),
        .ram_addr(ram_addr), .ram_in_data(ram_in_data),
        .ram_out_data(ram_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read byte RAM
    always @(posedge clk) begin
        if (ram_wr === 1'b1) mem[ram_addr] <= ram_in_data;
        if (ram_rd === 1'b1) ram_out_data <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe sanity every cycle and scoreboard pop on each RAM write
    always @(negedge clk) begin
        logic [31:0] e;
        if (started) begin
            chk("rd_vs_wr", {31'd0, ram_rd}, {31'd0, ~ram_wr});
            chk("bit_addr", {31'd0, ram_is_bit_addr}, 32'd0);
            if (ram_wr === 1'b1) begin
                e = (exp_wr.size() > 0) ? {16'd0, exp_wr.pop_front()}
                                        : 32'h1_0000;
                chk("ram_write", {16'd0, ram_addr, ram_in_data}, e);
            end
        end
    end

    task automatic op(input logic p, input logic po, input logic c,
                      input logic r, input logic [15:0] d,
                      input int exp_lat, input logic hold_pop);
        int lat;
        req_push  = p;
        req_pop   = po;
        req_call  = c;
        req_ret   = r;
        push_data = d[7:0];
        call_pc   = d;
        @(negedge clk);
        req_push  = 1'b0;
        req_call  = 1'b0;
        req_ret   = 1'b0;
        req_pop   = hold_pop;
        push_data = 8'hEE;
        call_pc   = 16'hEEEE;
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        req_pop = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic load_sp(input logic [7:0] v);
        sp_wr    = 1'b1;
        sp_wdata = v;
        @(negedge clk);
        sp_wr    = 1'b0;
        chk("sp_load", {24'd0, sp}, {24'd0, v});
        chk("sp_load_addr", {24'd0, ram_addr}, {24'd0, v});
        chk("sp_load_ovf", {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_out_data = 8'h00;
        rst = 1'b0;
        {req_push, req_pop, req_call, req_ret, sp_wr} = 5'b0;
        push_data = 8'h00;
        call_pc   = 16'h0000;
        sp_wdata  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sp", {24'd0, sp}, 32'h07);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_pop", {24'd0, pop_data}, 32'h00);
        chk("rst_ret", {16'd0, ret_pc}, 32'h0000);
        chk("rst_rd", {31'd0, ram_rd}, 32'd1);
        chk("rst_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_addr", {24'd0, ram_addr}, 32'h07);
        chk("rst_wdata", {24'd0, ram_in_data}, 32'h00);
        rst = 1'b1;
        started = 1;

        exp_wr.push_back(16'h08A5);
        op(1, 0, 0, 0, 16'h00A5, 2, 0);
        chk("push_sp", {24'd0, sp}, 32'h08);

        op(0, 1, 0, 0, 16'h0000, 3, 0);
        chk("pop_data", {24'd0, pop_data}, 32'hA5);
        chk("pop_sp", {24'd0, sp}, 32'h07);

        exp_wr.push_back(16'h0834);
        exp_wr.push_back(16'h0912);
        op(0, 0, 1, 0, 16'h1234, 3, 0);
        chk("call_sp", {24'd0, sp}, 32'h09);

        op(0, 0, 0, 1, 16'h0000, 4, 0);
        chk("ret_pc", {16'd0, ret_pc}, 32'h1234);
        chk("ret_sp", {24'd0, sp}, 32'h07);

        exp_wr.push_back(16'h083C);
        op(1, 1, 0, 0, 16'h003C, 2, 1);
        chk("prio_sp", {24'd0, sp}, 32'h08);
        @(negedge clk);
        chk("prio_sp_late", {24'd0, sp}, 32'h08);
        chk("prio_busy_late", {31'd0, busy}, 32'd0);

        op(0, 1, 0, 0, 16'h0000, 3, 0);
        chk("pop2_data", {24'd0, pop_data}, 32'h3C);
        chk("pop2_sp", {24'd0, sp}, 32'h07);

        load_sp(8'h7F);
`ifdef STACK_GUARD_EN
        op(1, 0, 0, 0, 16'h0055, 1, 0);
        chk("guard_sp", {24'd0, sp}, 32'h7F);
        chk("guard_ovf", {31'd0, ovf}, 32'd1);
`else
        exp_wr.push_back(16'h8055);
        op(1, 0, 0, 0, 16'h0055, 2, 0);
        chk("nog_sp", {24'd0, sp}, 32'h80);
        chk("nog_ovf", {31'd0, ovf}, 32'd0);
`endif
        load_sp(8'h07);

        exp_wr.push_back(16'h08CD);
        exp_wr.push_back(16'h09AB);
        op(0, 0, 1, 1, 16'hABCD, 3, 0);
        chk("cr_sp", {24'd0, sp}, 32'h09);
        op(0, 0, 0, 1, 16'h0000, 4, 0);
        chk("ret2_pc", {16'd0, ret_pc}, 32'hABCD);
        chk("pop_hold", {24'd0, pop_data}, 32'h3C);

        load_sp(8'hFF);
`ifdef STACK_GUARD_EN
        op(1, 0, 0, 0, 16'h0077, 1, 0);
        chk("wrap_g_sp", {24'd0, sp}, 32'hFF);
        chk("wrap_g_ovf", {31'd0, ovf}, 32'd1);
        load_sp(8'h07);
        op(0, 1, 0, 0, 16'h0000, 1, 0);
        chk("ufl_sp", {24'd0, sp}, 32'h07);
        chk("ufl_pop", {24'd0, pop_data}, 32'h3C);
        chk("ufl_ovf", {31'd0, ovf}, 32'd1);
`else
        exp_wr.push_back(16'h0077);
        op(1, 0, 0, 0, 16'h0077, 2, 0);
        chk("wrap_sp", {24'd0, sp}, 32'h00);
        op(0, 1, 0, 0, 16'h0000, 3, 0);
        chk("wrap_pop", {24'd0, pop_data}, 32'h77);
        chk("wrap_pop_sp", {24'd0, sp}, 32'hFF);
`endif
        load_sp(8'h07);

        exp_wr.push_back(16'h0878);
        req_call = 1'b1;
        call_pc  = 16'h5678;
        @(negedge clk);
        req_call = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sp", {24'd0, sp}, 32'h07);
        chk("abort_wr", {31'd0, ram_wr}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_wr", {31'd0, ram_wr}, 32'd0);

        chk("wr_left", exp_wr.size(), 0);
        started = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
